pim_dma_master: RTL

PIM_DMA_MASTER -- requirements
Module: pim_dma_master

---
 rtl/pim_dma_master_if.sv | 43 ++++
 rtl/pim_dma_master.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/pim_dma_master_if.sv
// ---------------------------------------------------------------------------
// pim_dma_master_if
//   Bus bundle between the PIM DMA master and the PIM buffer / PIM arbiter.
//   Handshake : o_req (request), i_gnt (grant)
//   Port 0    : read side (PIM buffer)  o_addr_0, o_read_0, o_write_0, o_size_0,
//               o_din_0, i_dout_0
//   Port 1    : write side (PIM array)  o_addr_1, o_read_1, o_write_1, o_size_1,
//               o_din_1
//   Signal names keep the master's point of view (o_* driven by master).
// ---------------------------------------------------------------------------
interface pim_dma_master_if;
    logic        o_req;
    logic        i_gnt;

    logic [31:0] o_addr_0;
    logic        o_read_0;
    logic        o_write_0;
    logic [3:0]  o_size_0;
    logic [31:0] o_din_0;
    logic [31:0] i_dout_0;

    logic [31:0] o_addr_1;
    logic        o_read_1;
    logic        o_write_1;
    logic [3:0]  o_size_1;
    logic [31:0] o_din_1;

    modport master (
        output o_req,
        input  i_gnt,
        output o_addr_0, o_read_0, o_write_0, o_size_0, o_din_0,
        input  i_dout_0,
        output o_addr_1, o_read_1, o_write_1, o_size_1, o_din_1
    );

    modport slave (
        input  o_req,
        output i_gnt,
        input  o_addr_0, o_read_0, o_write_0, o_size_0, o_din_0,
        output i_dout_0,
        input  o_addr_1, o_read_1, o_write_1, o_size_1, o_din_1
    );
endinterface

// File: rtl/pim_dma_master.sv
// ---------------------------------------------------------------------------
// pim_dma_master
//   Copies i_len 32-bit words from the PIM buffer (port 0, reads) to the PIM
//   array (port 1, writes) under a request/grant bus handshake.
//
//   Ports
//     i_clk, i_rst_n        clock, asynchronous active-low reset
//     i_start               one-cycle launch, honoured only when idle
//     i_src_addr/i_dst_addr word-aligned source (0x2xxx_xxxx) / dest (0x4xxx_xxxx)
//     i_len                 length in words (0 completes immediately)
//     o_busy                high in every state except idle
//     o_done / o_err        one-cycle completion pulse / address-check error
//     bus                   pim_dma_master_if.master (handshake + both ports)
//
//   Build option
//     DMA_PIPE_EN  defined   : write n and read n+1 share a granted cycle
//                              (1 word/cycle, L+1 granted cycles).
//                  undefined : reads and writes alternate (2L granted cycles).
// ---------------------------------------------------------------------------
module pim_dma_master (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [31:0]      i_src_addr,
    input  logic [31:0]      i_dst_addr,
    input  logic [15:0]      i_len,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_err,
    pim_dma_master_if.master bus
);

    typedef enum logic [2:0] {StIdle, StReq, StXfer, StDrain, StDone} state_e;

    state_e      state_q, state_d;
    logic [31:0] src_q, src_d;
    logic [31:0] dst_q, dst_d;
    logic [15:0] len_q, len_d;
    logic [15:0] rd_cnt_q, rd_cnt_d;   // reads issued
    logic [15:0] wr_cnt_q, wr_cnt_d;   // writes completed
    logic [31:0] hold_q, hold_d;       // last read word, survives grant gaps
    logic        rd_just_q;            // a read was accepted in the previous cycle
    logic        err_q, err_d;

    logic        rd_en;
    logic        wr_en;
    logic        bad_addr;
    logic        have_word;
    logic        rd_last;

    assign bad_addr  = (i_src_addr[31:28] != 4'h2) || (i_dst_addr[31:28] != 4'h4) ||
                       (|i_src_addr[1:0]) || (|i_dst_addr[1:0]);
    // One word read but not yet written.
    assign have_word = (rd_cnt_q != wr_cnt_q);
    assign rd_last   = ((rd_cnt_q + 16'd1) == len_q);

    always_comb begin
        state_d  = state_q;
        src_d    = src_q;
        dst_d    = dst_q;
        len_d    = len_q;
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        err_d    = err_q;
        rd_en    = 1'b0;
        wr_en    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (i_start) begin
                    src_d    = i_src_addr;
                    dst_d    = i_dst_addr;
                    len_d    = i_len;
                    rd_cnt_d = 16'd0;
                    wr_cnt_d = 16'd0;
                    err_d    = bad_addr;
                    if (bad_addr || (i_len == 16'd0)) begin
                        state_d = StDone;
                    end else begin
                        state_d = StReq;
                    end
                end
            end
            StReq: begin
                if (bus.i_gnt) begin
                    state_d = StXfer;
                end
            end
            StXfer: begin
                // Without grant nothing moves: counters and addresses freeze.
                if (bus.i_gnt) begin
`ifdef DMA_PIPE_EN
                    wr_en = have_word;
                    rd_en = 1'b1;
`else
                    wr_en = have_word;
                    rd_en = !have_word;
`endif
                    if (rd_en && rd_last) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (bus.i_gnt) begin
                    wr_en   = 1'b1;
                    state_d = StDone;
                end
            end
            StDone: begin
                err_d   = 1'b0;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (rd_en) begin
            rd_cnt_d = rd_cnt_q + 16'd1;
        end
        if (wr_en) begin
            wr_cnt_d = wr_cnt_q + 16'd1;
        end
    end

    // Read data arrives the cycle after the accepted read; capture it then.
    assign hold_d = rd_just_q ? bus.i_dout_0 : hold_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= StIdle;
            src_q     <= 32'd0;
            dst_q     <= 32'd0;
            len_q     <= 16'd0;
            rd_cnt_q  <= 16'd0;
            wr_cnt_q  <= 16'd0;
            hold_q    <= 32'd0;
            rd_just_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            len_q     <= len_d;
            rd_cnt_q  <= rd_cnt_d;
            wr_cnt_q  <= wr_cnt_d;
            hold_q    <= hold_d;
            rd_just_q <= rd_en;
            err_q     <= err_d;
        end
    end

    assign o_busy = (state_q != StIdle);
    assign o_done = (state_q == StDone);
    assign o_err  = (state_q == StDone) && err_q;

    assign bus.o_req = (state_q == StReq) || (state_q == StXfer) || (state_q == StDrain);

    // Addresses advance by one word per transfer and wrap modulo 2^32.
    assign bus.o_addr_0  = src_q + {14'd0, rd_cnt_q, 2'b00};
    assign bus.o_read_0  = rd_en;
    assign bus.o_write_0 = 1'b0;
    assign bus.o_size_0  = rd_en ? 4'hF : 4'h0;
    assign bus.o_din_0   = 32'd0;

    // Forward live read data directly after the read, otherwise the held copy.
    assign bus.o_addr_1  = dst_q + {14'd0, wr_cnt_q, 2'b00};
    assign bus.o_read_1  = 1'b0;
    assign bus.o_write_1 = wr_en;
    assign bus.o_size_1  = wr_en ? 4'hF : 4'h0;
    assign bus.o_din_1   = rd_just_q ? bus.i_dout_0 : hold_q;

endmodule
